// File: rtl/elevator_scheduler.sv
// Collective-selective motion and request scheduler for a 2-way, 7-floor car.
// Latches hall/car calls, steps the car floor by floor and sequences door dwell.
module elevator_scheduler #(
  parameter logic [31:0] CLK_PER_FLOOR = 32'd100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:1] hallUp,
  input  logic [7:1] hallDown,
  input  logic [7:1] carCall,
  input  logic       doorState,
  output logic [2:0] currentFloor,
  output logic [1:0] currentDirection,
  output logic [1:0] currentFloorButton,
  output logic       moving,
  output logic [7:1] upPending,
  output logic [7:1] downPending,
  output logic [7:1] carPending
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_ARRIVE, S_DWELL, S_RESUME} state_e;
  typedef enum logic [1:0] {DIR_STOP = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10} dir_e;

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [2:0]  floor_q, floor_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dwell_seen_q;
  logic [7:1]  up_q, up_d, dn_q, dn_d, car_q, car_d;

  logic [7:0]  fl_oh, le_m, lt_m;
  logic [7:1]  here, above_m, below_m, any_req, blk, clr;
  logic        up_here, dn_here, car_here, above, below;
  logic        fwd_up, fwd_dn, hall_fwd, hall_opp, ahead, behind;
  dir_e        flip;

  // Floor masks from a one-hot of the current floor (bit 0 unused).
  assign fl_oh   = 8'd1 << floor_q;
  assign le_m    = (fl_oh << 1) - 8'd1;
  assign lt_m    = fl_oh - 8'd1;
  assign here    = fl_oh[7:1];
  assign above_m = ~le_m[7:1];
  assign below_m = lt_m[7:1];

  assign any_req  = up_q | dn_q | car_q;
  assign above    = |(any_req & above_m);
  assign below    = |(any_req & below_m);
  assign up_here  = |(up_q & here);
  assign dn_here  = |(dn_q & here);
  assign car_here = |(car_q & here);

  assign fwd_up   = (dir_q == DIR_UP);
  assign fwd_dn   = (dir_q == DIR_DOWN);
  assign hall_fwd = (fwd_up & up_here) | (fwd_dn & dn_here);
  assign hall_opp = (fwd_up & dn_here) | (fwd_dn & up_here);
  assign ahead    = (fwd_up & above) | (fwd_dn & below);
  assign behind   = (fwd_up & below) | (fwd_dn & above);
  assign flip     = fwd_up ? DIR_DOWN : DIR_UP;

  // Calls being served at this floor are neither latched nor kept while dwelling.
  assign blk = (state_q == S_DWELL) ? here : '0;
  assign clr = (state_q == S_DWELL && !dwell_seen_q) ? here : '0;

  always_comb begin
    up_d  = ((up_q & ~(fwd_up ? clr : '0)) | (hallUp & ~(fwd_up ? blk : '0))) & 7'b0111111;
    dn_d  = ((dn_q & ~(fwd_dn ? clr : '0)) | (hallDown & ~(fwd_dn ? blk : '0))) & 7'b1111110;
    car_d = (car_q & ~clr) | (carCall & ~blk);
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (up_here || car_here) begin
          dir_d   = DIR_UP;
          state_d = S_DWELL;
        end else if (dn_here) begin
          dir_d   = DIR_DOWN;
          state_d = S_DWELL;
        end else if (above) begin
          dir_d   = DIR_UP;
          state_d = S_MOVE;
          cnt_d   = CLK_PER_FLOOR - 32'd1;
        end else if (below) begin
          dir_d   = DIR_DOWN;
          state_d = S_MOVE;
          cnt_d   = CLK_PER_FLOOR - 32'd1;
        end
      end
      S_MOVE: begin
        if (cnt_q == '0) begin
          floor_d = fwd_up ? floor_q + 3'd1 : floor_q - 3'd1;
          state_d = S_ARRIVE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ARRIVE: begin
        if (car_here || hall_fwd) begin
          state_d = S_DWELL;
        end else if (!ahead) begin
          if (hall_opp) begin
            dir_d   = flip;
            state_d = S_DWELL;
          end else if (behind) begin
            dir_d   = flip;
            state_d = S_MOVE;
            cnt_d   = CLK_PER_FLOOR - 32'd1;
          end else begin
            dir_d   = DIR_STOP;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_MOVE;
          cnt_d   = CLK_PER_FLOOR - 32'd1;
        end
      end
      S_DWELL: begin
        if (dwell_seen_q && !doorState) state_d = S_RESUME;
      end
      S_RESUME: begin
        if (ahead) begin
          state_d = S_MOVE;
          cnt_d   = CLK_PER_FLOOR - 32'd1;
        end else if (behind) begin
          dir_d   = flip;
          state_d = S_MOVE;
          cnt_d   = CLK_PER_FLOOR - 32'd1;
        end else if (hall_opp) begin
          dir_d   = flip;
          state_d = S_DWELL;
        end else begin
          dir_d   = DIR_STOP;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dir_q        <= DIR_STOP;
      floor_q      <= 3'd1;
      cnt_q        <= '0;
      dwell_seen_q <= 1'b0;
      up_q         <= '0;
      dn_q         <= '0;
      car_q        <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      floor_q      <= floor_d;
      cnt_q        <= cnt_d;
      dwell_seen_q <= (state_q == S_DWELL);
      up_q         <= up_d;
      dn_q         <= dn_d;
      car_q        <= car_d;
    end
  end

  assign currentFloor       = floor_q;
  assign currentDirection   = dir_q;
  assign currentFloorButton = {dn_here, up_here};
  assign moving             = (state_q == S_MOVE);
  assign upPending          = up_q;
  assign downPending        = dn_q;
  assign carPending         = car_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a floor/request-level reference model is checked
// against all outputs every cycle, alongside directed hand-computed expectations.
module tb_elevator_scheduler;

  localparam int N = 4;
  localparam int PH_IDLE = 0, PH_TRAVEL = 1, PH_ARRIVE = 2, PH_DWELL = 3, PH_RESUME = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] hallUp, hallDown, carCall;
  logic       doorState;
  logic [2:0] currentFloor;
  logic [1:0] currentDirection, currentFloorButton;
  logic       moving;
  logic [7:1] upPending, downPending, carPending;

  elevator_scheduler #(.CLK_PER_FLOOR(32'd4)) dut (
    .clk(clk), .reset(reset), .hallUp(hallUp), .hallDown(hallDown), .carCall(carCall),
    .doorState(doorState), .currentFloor(currentFloor), .currentDirection(currentDirection),
    .currentFloorButton(currentFloorButton), .moving(moving), .upPending(upPending),
    .downPending(downPending), .carPending(carPending)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: floor as an integer, direction as +1/0/-1, requests as bit arrays.
  int m_floor, m_dir, m_phase, m_left, m_age;
  bit m_up[1:7], m_dn[1:7], m_car[1:7];
  bit m_valid = 1'b0;

  function automatic bit m_any(int g);
    return m_up[g] | m_dn[g] | m_car[g];
  endfunction

  function automatic bit m_ahead(int d);
    for (int g = 1; g <= 7; g++)
      if ((g - m_floor) * d > 0 && m_any(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hall(int d);
    if (d > 0) return m_up[m_floor];
    if (d < 0) return m_dn[m_floor];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int np, nd, nf, nl, na;
    if (reset) begin
      m_floor = 1; m_dir = 0; m_phase = PH_IDLE; m_left = 0; m_age = 0;
      for (int g = 1; g <= 7; g++) begin m_up[g] = 0; m_dn[g] = 0; m_car[g] = 0; end
      m_valid = 1'b1;
    end else if (m_valid) begin
      np = m_phase; nd = m_dir; nf = m_floor; nl = m_left; na = m_age;
      case (m_phase)
        PH_IDLE:
          if (m_up[m_floor] || m_car[m_floor]) begin nd = 1; np = PH_DWELL; na = 0; end
          else if (m_dn[m_floor]) begin nd = -1; np = PH_DWELL; na = 0; end
          else if (m_ahead(1)) begin nd = 1; np = PH_TRAVEL; nl = N; end
          else if (m_ahead(-1)) begin nd = -1; np = PH_TRAVEL; nl = N; end
        PH_TRAVEL: begin
          nl = m_left - 1;
          if (nl == 0) begin nf = m_floor + m_dir; np = PH_ARRIVE; end
        end
        PH_ARRIVE:
          if (m_car[m_floor] || m_hall(m_dir)) begin np = PH_DWELL; na = 0; end
          else if (!m_ahead(m_dir)) begin
            if (m_hall(-m_dir)) begin nd = -m_dir; np = PH_DWELL; na = 0; end
            else if (m_ahead(-m_dir)) begin nd = -m_dir; np = PH_TRAVEL; nl = N; end
            else begin nd = 0; np = PH_IDLE; end
          end else begin np = PH_TRAVEL; nl = N; end
        PH_DWELL: begin
          na = m_age + 1;
          if (na >= 2 && !doorState) np = PH_RESUME;
        end
        PH_RESUME:
          if (m_ahead(m_dir)) begin np = PH_TRAVEL; nl = N; end
          else if (m_ahead(-m_dir)) begin nd = -m_dir; np = PH_TRAVEL; nl = N; end
          else if (m_hall(-m_dir)) begin nd = -m_dir; np = PH_DWELL; na = 0; end
          else begin nd = 0; np = PH_IDLE; end
        default: ;
      endcase
      for (int g = 1; g <= 7; g++) begin
        bit blk, clr;
        blk = (m_phase == PH_DWELL) && (g == m_floor);
        clr = blk && (m_age == 0);
        m_up[g]  = (g != 7) && ((m_up[g] && !(clr && m_dir > 0)) || (hallUp[g] && !(blk && m_dir > 0)));
        m_dn[g]  = (g != 1) && ((m_dn[g] && !(clr && m_dir < 0)) || (hallDown[g] && !(blk && m_dir < 0)));
        m_car[g] = (m_car[g] && !clr) || (carCall[g] && !blk);
      end
      m_phase = np; m_dir = nd; m_floor = nf; m_left = nl; m_age = na;
    end
  end

  always @(negedge clk) begin
    logic [7:1] eu, ed, ec;
    logic [1:0] edir, eb;
    logic [2:0] ef;
    logic       em;
    if (m_valid) begin
      for (int g = 1; g <= 7; g++) begin eu[g] = m_up[g]; ed[g] = m_dn[g]; ec[g] = m_car[g]; end
      edir = (m_dir > 0) ? 2'b01 : (m_dir < 0) ? 2'b10 : 2'b00;
      eb   = {m_dn[m_floor], m_up[m_floor]};
      ef   = 3'(m_floor);
      em   = (m_phase == PH_TRAVEL);
      tests++;
      if (currentFloor !== ef || currentDirection !== edir || moving !== em ||
          currentFloorButton !== eb || upPending !== eu || downPending !== ed || carPending !== ec) begin
        fails++;
        $display("FAIL model t=%0t: got floor=%0d dir=%b mov=%b btn=%b up=%b dn=%b car=%b; required floor=%0d dir=%b mov=%b btn=%b up=%b dn=%b car=%b",
                 $time, currentFloor, currentDirection, moving, currentFloorButton, upPending, downPending,
                 carPending, ef, edir, em, eb, eu, ed, ec);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic wait_fm(input string nm, input logic [2:0] f, input logic mv, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (currentFloor == f && moving == mv) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: wait expired, got floor=%0d moving=%b required floor=%0d moving=%b",
               nm, currentFloor, moving, f, mv);
    end
  endtask

  task automatic wait_dir(input string nm, input logic [1:0] d, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (currentDirection == d) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: wait expired, got dir=%b required dir=%b", nm, currentDirection, d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int mv_cnt;
    reset = 1'b1; hallUp = '0; hallDown = '0; carCall = '0; doorState = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_floor", 32'(currentFloor), 32'd1);
    chk("rst_dir", 32'(currentDirection), 32'd0);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_pending", 32'({upPending, downPending, carPending}), 32'd0);

    // Buttons that do not exist on the end floors.
    hallUp = 7'b1000000; hallDown = 7'b0000001;
    @(negedge clk);
    hallUp = '0; hallDown = '0;
    @(negedge clk);
    chk("edge_up7", 32'(upPending), 32'd0);
    chk("edge_dn1", 32'(downPending), 32'd0);
    chk("edge_idle", 32'({currentDirection, moving}), 32'd0);

    // Car call to floor 3.
    carCall = 7'b0000100;
    @(negedge clk);
    carCall = '0;
    chk("car_latch", 32'(carPending), 32'b0000100);
    chk("car_dir_latency", 32'(currentDirection), 32'd0);
    mv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (moving) mv_cnt++;
    end
    chk("car_move_cycles", 32'(mv_cnt), 32'd8);
    chk("car_floor", 32'(currentFloor), 32'd3);
    chk("car_idle_dir", 32'(currentDirection), 32'd0);
    chk("car_cleared", 32'(carPending), 32'd0);

    // Reversal at the topmost call.
    do_reset();
    hallDown = 7'b0010000;
    @(negedge clk);
    hallDown = '0;
    wait_dir("rev_wait", 2'b10, 40);
    chk("rev_floor", 32'(currentFloor), 32'd5);
    chk("rev_moving", 32'(moving), 32'd0);
    chk("rev_btn", 32'(currentFloorButton), 32'b10);
    @(negedge clk);
    chk("rev_clear", 32'(downPending), 32'd0);
    chk("rev_btn_clear", 32'(currentFloorButton), 32'd0);
    repeat (4) @(negedge clk);
    chk("rev_idle", 32'(currentDirection), 32'd0);

    // Direction priority: an opposite hall call is passed on the way up.
    do_reset();
    carCall = 7'b0100000;
    @(negedge clk);
    carCall = '0;
    wait_fm("pri_at4", 3'd4, 1'b1, 40);
    hallDown = 7'b0010000;
    @(negedge clk);
    hallDown = '0;
    chk("pri_dn_latch", 32'(downPending), 32'b0010000);
    wait_dir("pri_flip", 2'b10, 40);
    chk("pri_flip_floor", 32'(currentFloor), 32'd6);
    chk("pri_flip_moving", 32'(moving), 32'd1);
    chk("pri_car6_clear", 32'(carPending), 32'd0);
    wait_fm("pri_at5", 3'd5, 1'b0, 20);
    chk("pri_arr_dir", 32'(currentDirection), 32'b10);
    chk("pri_arr_btn", 32'(currentFloorButton), 32'b10);
    repeat (2) @(negedge clk);
    chk("pri_dn_clear", 32'(downPending), 32'd0);
    repeat (4) @(negedge clk);
    chk("pri_idle", 32'({currentFloor, currentDirection}), 32'({3'd5, 2'b00}));

    // Door held open while the served calls are pressed again.
    do_reset();
    carCall = 7'b0000100; doorState = 1'b1;
    @(negedge clk);
    carCall = '0;
    wait_fm("door_at3", 3'd3, 1'b0, 40);
    @(negedge clk);
    hallUp = 7'b0000100; carCall = 7'b0000100;
    repeat (20) @(negedge clk);
    chk("door_up_blocked", 32'(upPending), 32'd0);
    chk("door_car_blocked", 32'(carPending), 32'd0);
    chk("door_hold", 32'({currentFloor, currentDirection, moving}), 32'({3'd3, 2'b01, 1'b0}));
    hallUp = '0; carCall = '0; doorState = 1'b0;
    @(negedge clk);
    chk("door_resume_dir", 32'(currentDirection), 32'b01);
    @(negedge clk);
    chk("door_idle_dir", 32'(currentDirection), 32'd0);

    // Reset in the second travel cycle away from floor 3.
    carCall = 7'b0010000;
    @(negedge clk);
    carCall = '0;
    @(negedge clk);
    chk("mrst_moving", 32'({currentFloor, moving}), 32'({3'd3, 1'b1}));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_floor", 32'(currentFloor), 32'd1);
    chk("mrst_moving0", 32'(moving), 32'd0);
    chk("mrst_dir", 32'(currentDirection), 32'd0);
    chk("mrst_pending", 32'({upPending, downPending, carPending}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Motion and request-scheduling stage for the 2-way, 7-floor elevator. It latches hall calls and car calls and runs a collective-selective scheduling state machine. It steps the car floor by floor with a travel timer and produces `currentFloor`, `currentDirection` and `currentFloorButton`, which the door controller consumes. `moving` drives the door controller's reset, and door-controller `doorState` feeds back to end each dwell.

## Interface
- `CLK_PER_FLOOR`, 100000000: clock cycles spent travelling between adjacent floors; 32-bit, must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `hallUp`  in  [7:1]  hall up buttons, level; bit 7 ignored.
- `hallDown`  in  [7:1]  hall down buttons, level; bit 1 ignored.
- `carCall`  in  [7:1]  car floor buttons, level.
- `doorState`  in  1  1 = door open (from door controller).
- `currentFloor`  out  [2:0]  floor 1..7.
- `currentDirection`  out  [1:0]  00 STOP, 01 UP, 10 DOWN.
- `currentFloorButton`  out  [1:0]  {downPending[f], upPending[f]} at `currentFloor` f.
- `moving`  out  1  high only in MOVE; wired to door reset.
- `upPending`, `downPending`, `carPending`  out  [7:1]  latched requests (lamps).

## Operation
- **Request latching**
  - A button high on any cycle sets its pending bit at the next edge.
  - `upPending[7]` and `downPending[1]` are constant 0.
  - Set wins over clear on the same edge, with one exception: during DWELL, `carCall[f]` and the hall button at f matching `currentDirection` are not latched.
- **Derived signals**
  - `above` = any pending bit at floors > f.
  - `below` = any pending bit at floors < f.
- **States**
  - IDLE: direction STOP. Decisions, in priority order:
    - `upPending[f]` or `carPending[f]` → UP, go to DWELL.
    - Else `downPending[f]` → DOWN, go to DWELL.
    - Else `above` → UP, go to MOVE.
    - Else `below` → DOWN, go to MOVE.
    - Else stay in IDLE.
  - MOVE: load the counter with `CLK_PER_FLOOR-1` on entry and decrement each cycle. When the counter reaches 0, f ± 1 per direction, then go to ARRIVE.
  - ARRIVE: one cycle. Decisions, in priority order:
    - `carPending[f]` or the hall bit at f in the current direction → DWELL.
    - Else no requests further in the current direction:
      - Opposite hall bit at f → flip direction, go to DWELL.
      - Else requests exist in the opposite direction → flip direction, go to MOVE.
      - Else → IDLE.
    - Else → MOVE.
  - DWELL:
    - The entry cycle shows the pending bits unchanged on `currentFloorButton`.
    - At the end of the first DWELL cycle, clear `carPending[f]` and the hall bit at f matching the direction.
    - Exit after ≥ 2 DWELL cycles with `doorState`=0, to RESUME.
  - RESUME: one cycle.
    - Requests further in the current direction → MOVE.
    - Else requests in the opposite direction → flip direction, go to MOVE.
    - Else opposite hall bit at f → flip direction, go to DWELL.
    - Else → IDLE.
- The floor never leaves 1..7. At floor 7 UP and at floor 1 DOWN are unreachable by construction.

## Timing
- **Reset values:**
  - `currentFloor`=1, direction 00, `moving`=0.
  - All pending bits 0, state IDLE, counter 0.
  - Reset mid-MOVE aborts travel and returns the car to floor 1 immediately.
- **Latency:**
  - Button to pending bit: 1 cycle.
  - Pending bit to IDLE decision: 1 cycle.
  - Each floor hop: `CLK_PER_FLOOR` MOVE cycles plus 1 ARRIVE cycle.
- `currentFloor` changes only on the final MOVE edge.
- Direction changes only in IDLE, ARRIVE and RESUME, and never while `moving`=1.
- `doorState` is ignored outside DWELL.
- A door held open keeps DWELL indefinitely.

## Test plan
All cases use `CLK_PER_FLOOR`=4.

- **Reset:** assert `reset` for 2 cycles → floor 1, direction 00, `moving` 0, all pending 0.
- **Car call:** at floor 1, pulse `carCall[3]` → direction 01, `moving` high for 4+4 cycles, floor 2 passed via ARRIVE, DWELL at floor 3. `carPending[3]` clears after the first DWELL cycle. With `doorState`=0 → IDLE, direction 00.
- **Reversal at top call:** at floor 1, press `hallDown[5]` only → travel UP to 5. ARRIVE flips direction to 10 and `currentFloorButton`=2'b10 during DWELL. `downPending[5]` then clears.
- **Direction priority:** car moving UP from floor 4 toward `carCall[6]`; press `hallDown[5]` → the car passes 5 without DWELL and stops at 6. RESUME flips to DOWN, MOVE to 5, DWELL there.
- **Held door:** in DWELL at floor 3 UP, hold `doorState`=1 for 20 cycles and press `hallUp[3]` and `carCall[3]` → state stays DWELL and neither bit latches. Release the door → RESUME.
- **Mid-move reset:** assert `reset` in the 2nd MOVE cycle at floor 3 → next cycle floor 1, `moving` 0, all pending 0.
